// File: rtl/cpu_step_sequencer.sv
// cpu_step_sequencer: single-clock IF/ID/AL/EX/WB stage-enable sequencer for the
// 8-bit multi-cycle CPU. It adds fetch wait-states with a timeout fault,
// halt/resume, run/stop gating and a retired-instruction counter.
// Optional feature macro: CPU_SEQ_SINGLE_STEP_EN adds iSS_MODE/iSTEP ports.
//
// state | meaning
// IDLE  | no instruction in flight, waiting for run (or a step pulse)
// IF    | fetching; waits on iIF_READY, faults after too many not-ready cycles
// ID    | decode enable
// AL    | allocate enable
// EX    | execute enable, iHALT captured here
// WB    | write-back enable, instruction retired
// HALT  | stopped by HALT instruction until iRESUME
// FAULT | fetch timed out; left only by reset
module cpu_step_sequencer #(
  parameter int INSTR_CNT_W = 16,
  parameter int IF_TIMEOUT  = 15
) (
  input  logic                   iCLK,
  input  logic                   iRST,
  input  logic                   iRUN,
  input  logic                   iIF_READY,
  input  logic                   iHALT,
  input  logic                   iRESUME,
`ifdef CPU_SEQ_SINGLE_STEP_EN
  input  logic                   iSS_MODE,
  input  logic                   iSTEP,
`endif
  output logic                   oEN_IF,
  output logic                   oEN_ID,
  output logic                   oEN_AL,
  output logic                   oEN_EX,
  output logic                   oEN_WB,
  output logic [2:0]             oSTATE,
  output logic                   oBUSY,
  output logic                   oHALTED,
  output logic                   oFAULT,
  output logic [INSTR_CNT_W-1:0] oINSTR_CNT
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_IF    = 3'd1,
    ST_ID    = 3'd2,
    ST_AL    = 3'd3,
    ST_EX    = 3'd4,
    ST_WB    = 3'd5,
    ST_HALT  = 3'd6,
    ST_FAULT = 3'd7
  } state_t;

  localparam logic [7:0] LP_TIMEOUT = 8'(IF_TIMEOUT);

  state_t                 r_state;
  logic [7:0]             r_wait_cnt;
  logic                   r_halt_pending;
  logic [INSTR_CNT_W-1:0] r_instr_cnt;

  logic w_start;
  logic w_ss_stop;

`ifdef CPU_SEQ_SINGLE_STEP_EN
  // In single-step mode each instruction needs its own step pulse.
  assign w_start   = iRUN && (!iSS_MODE || iSTEP);
  assign w_ss_stop = iSS_MODE;
`else
  assign w_start   = iRUN;
  assign w_ss_stop = 1'b0;
`endif

  // Sequencer state, fetch wait counter, halt capture and retire counter.
  always_ff @(posedge iCLK) begin
    if (!iRST) begin
      r_state        <= ST_IDLE;
      r_wait_cnt     <= 8'd0;
      r_halt_pending <= 1'b0;
      r_instr_cnt    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) r_state <= ST_IF;
        end
        ST_IF: begin
          if (iIF_READY) begin
            r_wait_cnt <= 8'd0;
            r_state    <= ST_ID;
          end else if (r_wait_cnt == LP_TIMEOUT) begin
            r_state <= ST_FAULT;
          end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
        end
        ST_ID: r_state <= ST_AL;
        ST_AL: r_state <= ST_EX;
        ST_EX: begin
          r_halt_pending <= iHALT;
          r_state        <= ST_WB;
        end
        ST_WB: begin
          r_instr_cnt <= r_instr_cnt + 1'b1;
          if (r_halt_pending)  r_state <= ST_HALT;
          else if (!iRUN)      r_state <= ST_IDLE;
          else if (w_ss_stop)  r_state <= ST_IDLE;
          else                 r_state <= ST_IF;
        end
        ST_HALT: begin
          if (iRESUME) begin
            r_halt_pending <= 1'b0;
            r_state        <= ST_IDLE;
          end
        end
        ST_FAULT: r_state <= ST_FAULT;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  // Fetch enable also depends on memory readiness; the rest decode the state.
  assign oEN_IF     = (r_state == ST_IF) && iIF_READY;
  assign oEN_ID     = (r_state == ST_ID);
  assign oEN_AL     = (r_state == ST_AL);
  assign oEN_EX     = (r_state == ST_EX);
  assign oEN_WB     = (r_state == ST_WB);
  assign oSTATE     = r_state;
  assign oBUSY      = (r_state == ST_IF) || (r_state == ST_ID) || (r_state == ST_AL) ||
                      (r_state == ST_EX) || (r_state == ST_WB);
  assign oHALTED    = (r_state == ST_HALT);
  assign oFAULT     = (r_state == ST_FAULT);
  assign oINSTR_CNT = r_instr_cnt;

endmodule

// File: tb/tb_cpu_step_sequencer.sv
// Directed bench for cpu_step_sequencer. A default-parameter instance covers
// the main sequencing; a second instance (IF_TIMEOUT=3, 3-bit counter) shares
// the inputs and covers the short timeout and counter wrap.
module tb_cpu_step_sequencer;

  logic iCLK, iRST, iRUN, iIF_READY, iHALT, iRESUME;
`ifdef CPU_SEQ_SINGLE_STEP_EN
  logic iSS_MODE, iSTEP;
`endif

  logic        en_if, en_id, en_al, en_ex, en_wb, busy, halted, fault;
  logic [2:0]  state;
  logic [15:0] cnt;

  logic        t_en_if, t_en_id, t_en_al, t_en_ex, t_en_wb, t_busy, t_halted, t_fault;
  logic [2:0]  t_state;
  logic [2:0]  t_cnt;

  int checks = 0;
  int errors = 0;

  cpu_step_sequencer u_dut (
    .iCLK(iCLK), .iRST(iRST), .iRUN(iRUN), .iIF_READY(iIF_READY),
    .iHALT(iHALT), .iRESUME(iRESUME),
`ifdef CPU_SEQ_SINGLE_STEP_EN
    .iSS_MODE(iSS_MODE), .iSTEP(iSTEP),
`endif
    .oEN_IF(en_if), .oEN_ID(en_id), .oEN_AL(en_al), .oEN_EX(en_ex), .oEN_WB(en_wb),
    .oSTATE(state), .oBUSY(busy), .oHALTED(halted), .oFAULT(fault), .oINSTR_CNT(cnt)
  );

  cpu_step_sequencer #(.INSTR_CNT_W(3), .IF_TIMEOUT(3)) u_dut_to (
    .iCLK(iCLK), .iRST(iRST), .iRUN(iRUN), .iIF_READY(iIF_READY),
    .iHALT(iHALT), .iRESUME(iRESUME),
`ifdef CPU_SEQ_SINGLE_STEP_EN
    .iSS_MODE(iSS_MODE), .iSTEP(iSTEP),
`endif
    .oEN_IF(t_en_if), .oEN_ID(t_en_id), .oEN_AL(t_en_al), .oEN_EX(t_en_ex), .oEN_WB(t_en_wb),
    .oSTATE(t_state), .oBUSY(t_busy), .oHALTED(t_halted), .oFAULT(t_fault), .oINSTR_CNT(t_cnt)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic reset_dut();
    iRST = 1'b0;
    tick();
    iRST = 1'b1;
  endtask

  task automatic test_reset();
    iRST = 1'b0; iRUN = 1'b1; iIF_READY = 1'b1; iHALT = 1'b0; iRESUME = 1'b0;
    tick(); tick();
    checks++;
    if ({en_if, en_id, en_al, en_ex, en_wb, busy, halted, fault} !== 8'b0) begin
      errors++;
      $display("FAIL reset_flags got %b exp 00000000",
               {en_if, en_id, en_al, en_ex, en_wb, busy, halted, fault});
    end
    checks++;
    if (state !== 3'd0 || cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_state got state %0d cnt %0d exp 0 0", state, cnt);
    end
    iRST = 1'b1; iRUN = 1'b0;
  endtask

  task automatic test_free_run();
    reset_dut();
    iRUN = 1'b1; iIF_READY = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (state !== 3'(1 + i % 5)) begin
        errors++;
        $display("FAIL free_state cyc %0d got %0d exp %0d", i, state, 1 + i % 5);
      end
      checks++;
      if ({en_if, en_id, en_al, en_ex, en_wb} !== (5'b10000 >> (i % 5))) begin
        errors++;
        $display("FAIL free_enables cyc %0d got %b exp %b", i,
                 {en_if, en_id, en_al, en_ex, en_wb}, 5'b10000 >> (i % 5));
      end
      checks++;
      if (busy !== 1'b1 || cnt !== 16'(i / 5)) begin
        errors++;
        $display("FAIL free_busy_cnt cyc %0d got busy %b cnt %0d exp 1 %0d", i, busy, cnt, i / 5);
      end
    end
  endtask

  // Continues from WB left by test_free_run.
  task automatic test_wait_states();
    iIF_READY = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++;
      if (state !== 3'd1 || en_if !== 1'b0 || fault !== 1'b0) begin
        errors++;
        $display("FAIL wait_if cyc %0d got state %0d en_if %b fault %b exp 1 0 0",
                 k, state, en_if, fault);
      end
    end
    tick();
    iIF_READY = 1'b1;
    #1;
    checks++;
    if (state !== 3'd1 || en_if !== 1'b1) begin
      errors++;
      $display("FAIL wait_fetch got state %0d en_if %b exp 1 1", state, en_if);
    end
    tick();
    checks++;
    if (state !== 3'd2 || fault !== 1'b0) begin
      errors++;
      $display("FAIL wait_to_id got state %0d fault %b exp 2 0", state, fault);
    end
  endtask

  task automatic test_halt();
    iRUN = 1'b0; iIF_READY = 1'b1; iHALT = 1'b0; iRESUME = 1'b0;
    reset_dut();
    iRUN = 1'b1; iHALT = 1'b1;
    tick(); tick(); tick();            // IF, ID, AL with iHALT high
    iHALT = 1'b0;
    tick(); tick();                    // EX, WB
    tick();
    checks++;
    if (state !== 3'd1 || halted !== 1'b0 || cnt !== 16'd1) begin
      errors++;
      $display("FAIL halt_outside_ex got state %0d halted %b cnt %0d exp 1 0 1", state, halted, cnt);
    end
    tick(); tick(); tick();            // ID, AL, EX
    iHALT = 1'b1;
    tick();
    iHALT = 1'b0;
    checks++;
    if (state !== 3'd5 || en_wb !== 1'b1) begin
      errors++;
      $display("FAIL halt_wb got state %0d en_wb %b exp 5 1", state, en_wb);
    end
    tick();
    checks++;
    if (state !== 3'd6 || halted !== 1'b1 || busy !== 1'b0 || cnt !== 16'd2) begin
      errors++;
      $display("FAIL halt_enter got state %0d halted %b busy %b cnt %0d exp 6 1 0 2",
               state, halted, busy, cnt);
    end
    tick();
    checks++;
    if (state !== 3'd6) begin
      errors++;
      $display("FAIL halt_ignores_run got state %0d exp 6", state);
    end
    iRESUME = 1'b1;
    tick();
    iRESUME = 1'b0;
    checks++;
    if (state !== 3'd0 || halted !== 1'b0) begin
      errors++;
      $display("FAIL resume_idle got state %0d halted %b exp 0 0", state, halted);
    end
    tick();
    checks++;
    if (state !== 3'd1) begin
      errors++;
      $display("FAIL resume_if got state %0d exp 1", state);
    end
    tick(); tick(); tick(); tick(); tick();
    checks++;
    if (state !== 3'd1 || cnt !== 16'd3) begin
      errors++;
      $display("FAIL halt_pending_cleared got state %0d cnt %0d exp 1 3", state, cnt);
    end
  endtask

  task automatic test_stop_mid();
    iRUN = 1'b0; iIF_READY = 1'b1;
    reset_dut();
    iRUN = 1'b1;
    tick(); tick();                    // IF, ID
    iRUN = 1'b0;
    tick(); tick(); tick();            // AL, EX, WB
    checks++;
    if (state !== 3'd5) begin
      errors++;
      $display("FAIL stop_completes got state %0d exp 5", state);
    end
    tick();
    checks++;
    if (state !== 3'd0 || cnt !== 16'd1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL stop_idle got state %0d cnt %0d busy %b exp 0 1 0", state, cnt, busy);
    end
    iRUN = 1'b1;
    tick(); tick(); tick();            // IF, ID, AL
    checks++;
    if (state !== 3'd3) begin
      errors++;
      $display("FAIL rst_mid_pre got state %0d exp 3", state);
    end
    iRST = 1'b0;
    tick();
    checks++;
    if (state !== 3'd0 || cnt !== 16'd0 ||
        {en_if, en_id, en_al, en_ex, en_wb, busy, halted, fault} !== 8'b0) begin
      errors++;
      $display("FAIL rst_mid got state %0d cnt %0d flags %b exp 0 0 00000000", state, cnt,
               {en_if, en_id, en_al, en_ex, en_wb, busy, halted, fault});
    end
    iRST = 1'b1; iRUN = 1'b0;
  endtask

  task automatic test_timeout();
    iRUN = 1'b0;
    reset_dut();
    iRUN = 1'b1; iIF_READY = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++;
      if (t_state !== 3'd1 || t_fault !== 1'b0) begin
        errors++;
        $display("FAIL to3_if cyc %0d got state %0d fault %b exp 1 0", k, t_state, t_fault);
      end
    end
    tick();
    checks++;
    if (t_state !== 3'd7 || t_fault !== 1'b1 || t_busy !== 1'b0) begin
      errors++;
      $display("FAIL to3_fault got state %0d fault %b busy %b exp 7 1 0", t_state, t_fault, t_busy);
    end
    for (int k = 6; k <= 16; k++) tick();
    checks++;
    if (state !== 3'd1 || fault !== 1'b0) begin
      errors++;
      $display("FAIL to15_last_if got state %0d fault %b exp 1 0", state, fault);
    end
    tick();
    checks++;
    if (state !== 3'd7 || fault !== 1'b1) begin
      errors++;
      $display("FAIL to15_fault got state %0d fault %b exp 7 1", state, fault);
    end
    iIF_READY = 1'b1; iRESUME = 1'b1;
    tick(); tick(); tick();
    iRESUME = 1'b0;
    checks++;
    if (state !== 3'd7 || t_state !== 3'd7 || en_if !== 1'b0) begin
      errors++;
      $display("FAIL fault_sticky got state %0d t_state %0d en_if %b exp 7 7 0", state, t_state, en_if);
    end
    iRST = 1'b0;
    tick();
    checks++;
    if (state !== 3'd0 || t_state !== 3'd0 || fault !== 1'b0 || t_fault !== 1'b0 ||
        {en_if, en_id, en_al, en_ex, en_wb, busy, halted} !== 7'b0) begin
      errors++;
      $display("FAIL fault_reset got state %0d t_state %0d fault %b t_fault %b exp 0 0 0 0",
               state, t_state, fault, t_fault);
    end
    iRST = 1'b1; iRUN = 1'b0;
  endtask

  task automatic test_wrap();
    iRUN = 1'b0; iIF_READY = 1'b1;
    reset_dut();
    iRUN = 1'b1;
    for (int j = 1; j <= 41; j++) begin
      tick();
      if (j % 5 == 1) begin
        checks++;
        if (cnt !== 16'((j - 1) / 5) || t_cnt !== 3'(((j - 1) / 5) % 8)) begin
          errors++;
          $display("FAIL cnt_wrap cyc %0d got cnt %0d t_cnt %0d exp %0d %0d",
                   j, cnt, t_cnt, (j - 1) / 5, ((j - 1) / 5) % 8);
        end
      end
    end
    iRUN = 1'b0;
  endtask

`ifdef CPU_SEQ_SINGLE_STEP_EN
  task automatic test_single_step();
    iRUN = 1'b0; iIF_READY = 1'b1; iSS_MODE = 1'b1; iSTEP = 1'b0;
    reset_dut();
    iRUN = 1'b1;
    tick(); tick();
    checks++;
    if (state !== 3'd0) begin
      errors++;
      $display("FAIL ss_wait got state %0d exp 0", state);
    end
    for (int p = 1; p <= 3; p++) begin
      iSTEP = 1'b1;
      tick();
      iSTEP = 1'b0;
      tick(); tick(); tick(); tick();
      tick();
      checks++;
      if (state !== 3'd0 || cnt !== 16'(p)) begin
        errors++;
        $display("FAIL ss_step %0d got state %0d cnt %0d exp 0 %0d", p, state, cnt, p);
      end
      tick();
      checks++;
      if (state !== 3'd0) begin
        errors++;
        $display("FAIL ss_hold %0d got state %0d exp 0", p, state);
      end
    end
    iSS_MODE = 1'b0;
    tick();
    checks++;
    if (state !== 3'd1) begin
      errors++;
      $display("FAIL ss_off got state %0d exp 1", state);
    end
    iRUN = 1'b0;
  endtask
`endif

  initial begin
    iRST = 1'b0; iRUN = 1'b0; iIF_READY = 1'b0; iHALT = 1'b0; iRESUME = 1'b0;
`ifdef CPU_SEQ_SINGLE_STEP_EN
    iSS_MODE = 1'b0; iSTEP = 1'b0;
`endif
    test_reset();
    test_free_run();
    test_wait_states();
    test_halt();
    test_stop_mid();
    test_timeout();
    test_wrap();
`ifdef CPU_SEQ_SINGLE_STEP_EN
    test_single_step();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_step_sequencer.md
# cpu_step_sequencer

Single-clock instruction sequencer for the 8-bit multi-cycle CPU. It replaces the multi-clock step generator with one-cycle stage enables (IF, ID, AL, EX, WB) on the core clock. It adds fetch wait-states with a timeout, halt/resume control, run/stop gating and a retired-instruction counter. It sits beside the fetch, decode, allocate and execute stages and is their only sequencing source.

## Interface
- `INSTR_CNT_W`, default 16: width of the retired-instruction counter.
- `IF_TIMEOUT`, default 15: maximum consecutive not-ready fetch cycles before a fault (1..255).

Ports:
- `iCLK`  in  1  core clock; all state changes on the rising edge.
- `iRST`  in  1  synchronous, active-low reset.
- `iRUN`  in  1  level; run enable.
- `iIF_READY`  in  1  instruction memory has valid data this cycle.
- `iHALT`  in  1  decoded instruction is HALT; sampled only in state EX.
- `iRESUME`  in  1  one-cycle pulse; leaves HALT.
- `oEN_IF`, `oEN_ID`, `oEN_AL`, `oEN_EX`, `oEN_WB`  out  1 each  one-cycle stage enables.
- `oSTATE`  out  3  current state encoding.
- `oBUSY`  out  1  an instruction is in flight (state IF..WB).
- `oHALTED`  out  1  state is HALT.
- `oFAULT`  out  1  state is FAULT.
- `oINSTR_CNT`  out  INSTR_CNT_W  retired instructions.

## Operation
- States and encodings: IDLE=0, IF=1, ID=2, AL=3, EX=4, WB=5, HALT=6, FAULT=7.
- IDLE: go to IF when `iRUN`=1; otherwise stay in IDLE.
- IF: stay in IF while `iIF_READY`=0, incrementing the wait counter each such cycle.
  - If the wait counter equals `IF_TIMEOUT` while `iIF_READY`=0, go to FAULT.
  - When `iIF_READY`=1, assert `oEN_IF`, clear the wait counter and go to ID.
- ID, AL, EX: assert the matching enable for exactly one cycle, then advance to the next state unconditionally.
  - In EX, register `iHALT` into `halt_pending`.
- WB: assert `oEN_WB` and increment `oINSTR_CNT` (wraps modulo 2^INSTR_CNT_W). Next-state priority:
  - `halt_pending` → HALT;
  - else `iRUN`=0 → IDLE;
  - else single-step stop (see Configuration) → IDLE;
  - else → IF.
- HALT: on `iRESUME`=1, clear `halt_pending` and go to IDLE. `iRUN` is ignored in HALT.
- FAULT: sticky; only reset exits.
- Enable rules: at most one `oEN_*` is high in any cycle. `oEN_*` are registered-state decodes (Moore), except `oEN_IF`, which is `state==IF && iIF_READY`.
- Deasserting `iRUN` mid-instruction never aborts it; the instruction completes through WB.

## Timing
- Reset (`iRST`=0 at an edge), in any state including mid-instruction:
  - state←IDLE, wait counter←0, `halt_pending`←0, `oINSTR_CNT`←0.
  - All `oEN_*`, `oBUSY`, `oHALTED` and `oFAULT` are 0; `oSTATE`=0.
- Minimum instruction latency is 5 cycles (IF..WB) with `iIF_READY` held 1. Back-to-back throughput is 1 instruction per 5 cycles.
- Each 0 on `iIF_READY` adds one cycle. Timeout occurs on the cycle with the (`IF_TIMEOUT`+1)-th consecutive not-ready sample, so FAULT is entered after `IF_TIMEOUT`+1 IF cycles.
- First `oEN_IF` appears at the earliest 2 cycles after `iRUN` rises in IDLE: cycle 1 is IDLE→IF, cycle 2 is the IF fetch.
- `iRESUME` and `iRUN`=1 in the same cycle in HALT: the next state is IDLE, and IF follows one cycle later.
- `iHALT` outside EX has no effect.
- Counter wrap: from all-ones, the next WB gives 0 with no flag.

## Configuration
- `CPU_SEQ_SINGLE_STEP_EN` defined:
  - Adds input ports `iSS_MODE` (1, level) and `iSTEP` (1, pulse).
  - With `iSS_MODE`=1, WB goes to IDLE (when neither halt nor `iRUN`=0 applies). IDLE then starts exactly one instruction per `iSTEP` pulse, provided `iRUN`=1.
  - With `iSS_MODE`=0, behaviour is identical to the undefined case.
- `CPU_SEQ_SINGLE_STEP_EN` undefined: the ports are absent and the sequencer runs free whenever `iRUN`=1.

## Test plan
- Free run: reset, hold `iRUN`=1 and `iIF_READY`=1 for 20 cycles → enables cycle IF,ID,AL,EX,WB, one-hot; `oINSTR_CNT`=3 after cycle 17; `oBUSY`=1 from cycle 2.
- Wait states: hold `iIF_READY`=0 for 4 IF cycles, then 1 → `oEN_IF` fires on the 5th IF cycle; no FAULT.
- Timeout: `IF_TIMEOUT`=3, `iIF_READY` stuck at 0 → FAULT entered after 4 IF cycles; `oFAULT`=1 and `oSTATE`=7; it persists until `iRST`=0, after which everything is 0.
- Halt: assert `iHALT` during EX → WB, then HALT (`oHALTED`=1, `oINSTR_CNT` incremented). `iRESUME` pulse → IDLE next cycle, then IF.
- Stop/reset mid-instruction: drop `iRUN` in ID → the instruction completes and the sequencer goes to IDLE after WB. Separately, assert `iRST`=0 in AL → next cycle IDLE with all outputs 0.
- Single step (macro defined): `iSS_MODE`=1, `iRUN`=1, three `iSTEP` pulses → exactly 3 retirements; the sequencer is in IDLE between pulses.
